bpf_bank_sequencer: RTL and testbench

Time-multiplexes one shared biquad (SOS) engine across a bank of NFILT band-pass filters, two cascaded sections each. On every audio sample strobe it walks filter 0..NFILT-1, section 0 then 1, issuing start/done transactions to the engine and routing each section-0 result into section 1. It latches the per-band outputs and flags frame completion. It sits between the codec sample interface and the spectrum/power display logic, replacing per-band SOS pairs with a single engine plus coefficient select.

---
 rtl/bpf_pkg.sv | 27 ++
 rtl/bpf_txn_watchdog.sv | 27 ++
 rtl/bpf_bank_sequencer.sv | 165 ++++++++++++++++
 tb/tb_bpf_bank_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpf_pkg.sv
// Shared types and constants for the band-pass bank sequencer.
// Latency: n/a (package). Backpressure: n/a.
package bpf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } seq_state_t;

    localparam int NFILT_DEF   = 7;
    localparam int DW_DEF      = 27;
    localparam int OW_DEF      = 14;
    localparam int TIMEOUT_DEF = 64;

    localparam int IN_GUARD = 3;
    localparam int IN_FRAC  = 8;

    // Band output is taken just below the two guard bits of the engine result.
    localparam int OUT_SLICE_MSB = DW_DEF - 3;

    function automatic logic signed [DW_DEF-1:0] align_in(input logic signed [15:0] aud);
        return {{IN_GUARD{aud[15]}}, aud, {IN_FRAC{1'b0}}};
    endfunction

endpackage

// File: rtl/bpf_txn_watchdog.sv
// Per-transaction timeout counter: cleared at issue, counts while waiting.
// Latency: expire is combinational on the count reaching TIMEOUT-1. Backpressure: none.
module bpf_txn_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] cnt;

    assign expire = run && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (run && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bpf_bank_sequencer.sv
// Walks NFILT bands x 2 biquad sections through one shared SOS engine per sample.
// Latency: frame_valid 2*NFILT*(L+1)+1 cycles after the strobe. Backpressure: strobes while busy are dropped (overrun).
module bpf_bank_sequencer
    import bpf_pkg::*;
#(
    parameter int NFILT   = NFILT_DEF,
    parameter int DW      = DW_DEF,
    parameter int OW      = OW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       sample_stb,
    input  logic signed [15:0]         iAud,
    output logic                       eng_start,
    output logic [$clog2(NFILT)-1:0]   eng_filter,
    output logic                       eng_section,
    output logic signed [DW-1:0]       eng_in,
    input  logic                       eng_done,
    input  logic signed [DW-1:0]       eng_out,
    output logic [NFILT*OW-1:0]        oAud,
    output logic                       frame_valid,
    output logic                       busy,
    output logic                       overrun,
    output logic                       fault
);

    localparam int FW        = $clog2(NFILT);
    localparam int SLICE_MSB = OUT_SLICE_MSB + (DW - DW_DEF);

    seq_state_t state, state_nxt;

    logic signed [DW-1:0] x_reg;
    logic signed [DW-1:0] mid_reg;
    logic [FW-1:0]        filter;
    logic                 section;
    logic [OW-1:0]        band [NFILT];

    logic wd_clear;
    logic wd_run;
    logic wd_expire;
    logic last_filter;
    logic frame_start;
    logic sec_done;

    assign last_filter = (filter == FW'(NFILT - 1));
    assign frame_start = (state == ST_IDLE) && sample_stb && enable;
    assign sec_done    = (state == ST_WAIT) && eng_done;
    assign wd_run      = (state == ST_WAIT);

    assign busy        = (state != ST_IDLE);
    assign eng_filter  = filter;
    assign eng_section = section;
    assign eng_in      = section ? mid_reg : x_reg;

    bpf_txn_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wd_clear),
        .run    (wd_run),
        .expire (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        eng_start   = 1'b0;
        frame_valid = 1'b0;
        wd_clear    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sample_stb && enable) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                eng_start = 1'b1;
                wd_clear  = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving on the last counted cycle beats the timeout.
                if (eng_done) begin
                    state_nxt = (section && last_filter) ? ST_FINISH : ST_ISSUE;
                end else if (wd_expire) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FINISH: begin
                frame_valid = 1'b1;
                state_nxt   = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_reg   <= '0;
            mid_reg <= '0;
            filter  <= '0;
            section <= 1'b0;
        end else if (frame_start) begin
            x_reg   <= DW'(align_in(iAud));
            filter  <= '0;
            section <= 1'b0;
        end else if (sec_done) begin
            if (!section) begin
                mid_reg <= eng_out;
                section <= 1'b1;
            end else if (!last_filter) begin
                filter  <= filter + 1'b1;
                section <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
            fault   <= 1'b0;
        end else begin
            if (busy && sample_stb) begin
                overrun <= 1'b1;
            end
            if ((state == ST_WAIT) && !eng_done && wd_expire) begin
                fault <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int f = 0; f < NFILT; f++) begin
                band[f] <= '0;
            end
        end else if (sec_done && section) begin
            for (int f = 0; f < NFILT; f++) begin
                if (filter == FW'(f)) begin
                    band[f] <= eng_out[SLICE_MSB -: OW];
                end
            end
        end
    end

    always_comb begin
        oAud = '0;
        for (int f = 0; f < NFILT; f++) begin
            oAud[f*OW +: OW] = band[f];
        end
    end

endmodule

// File: tb/tb_bpf_bank_sequencer.sv
// Bench for bpf_bank_sequencer: behavioural SOS engine plus per-band reference model.
module tb_bpf_bank_sequencer;

    localparam int NFILT   = 7;
    localparam int DW      = 27;
    localparam int OW      = 14;
    localparam int TIMEOUT = 64;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     enable;
    logic                     sample_stb;
    logic signed [15:0]       iAud;
    logic                     eng_start;
    logic [2:0]               eng_filter;
    logic                     eng_section;
    logic signed [DW-1:0]     eng_in;
    logic                     eng_done;
    logic signed [DW-1:0]     eng_out;
    logic [NFILT*OW-1:0]      oAud;
    logic                     frame_valid;
    logic                     busy;
    logic                     overrun;
    logic                     fault;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0 = 0;

    int   eng_lat = 4;
    logic withhold = 1'b0;
    int   wh_f = 0;
    int   wh_s = 0;
    int   inject_cyc = -1;

    int                   st_cyc[$];
    int                   st_f[$];
    int                   st_s[$];
    logic signed [DW-1:0] st_in[$];

    logic [OW-1:0] exp_band [NFILT];

    bpf_bank_sequencer #(
        .NFILT   (NFILT),
        .DW      (DW),
        .OW      (OW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .sample_stb  (sample_stb),
        .iAud        (iAud),
        .eng_start   (eng_start),
        .eng_filter  (eng_filter),
        .eng_section (eng_section),
        .eng_in      (eng_in),
        .eng_done    (eng_done),
        .eng_out     (eng_out),
        .oAud        (oAud),
        .frame_valid (frame_valid),
        .busy        (busy),
        .overrun     (overrun),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine transfer function: section 0 adds the filter id, section 1 is a 0.75 gain plus offset.
    function automatic logic signed [DW-1:0] eng_model(input logic signed [DW-1:0] x, input int f, input int s);
        if (s == 0) return x + DW'(f);
        return x - (x >>> 2) + DW'(f * 2048);
    endfunction

    function automatic logic signed [DW-1:0] ref_x(input logic signed [15:0] aud);
        return DW'(int'(aud) * 256);
    endfunction

    function automatic logic [OW-1:0] ref_band(input logic signed [15:0] aud, input int f);
        logic signed [DW-1:0] y;
        y = eng_model(eng_model(ref_x(aud), f, 0), f, 1);
        return OW'(y >>> 11);
    endfunction

    initial begin : engine
        int cnt;
        logic pend;
        logic signed [DW-1:0] res;
        eng_done = 1'b0;
        eng_out  = '0;
        pend     = 1'b0;
        cnt      = 0;
        res      = '0;
        forever begin
            @(negedge clk);
            eng_done = 1'b0;
            if (reset) pend = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    eng_done = 1'b1;
                    eng_out  = res;
                    pend     = 1'b0;
                end
            end
            if (cyc == inject_cyc) begin
                eng_done = 1'b1;
                eng_out  = DW'($urandom);
            end
            if (eng_start) begin
                st_cyc.push_back(cyc - t0);
                st_f.push_back(int'(eng_filter));
                st_s.push_back(int'(eng_section));
                st_in.push_back(eng_in);
                res = eng_model(eng_in, int'(eng_filter), int'(eng_section));
                if (!(withhold && int'(eng_filter) == wh_f && int'(eng_section) == wh_s)) begin
                    pend = 1'b1;
                    cnt  = eng_lat;
                end
            end
        end
    end

    task automatic do_reset();
        reset      = 1'b1;
        sample_stb = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int f = 0; f < NFILT; f++) exp_band[f] = '0;
    endtask

    // Strobe at relative cycle 0 and run for bound cycles; optional extra strobe and enable drop.
    task automatic drive_frame(input logic signed [15:0] aud, input int lat, input int extra_stb,
                               input int en_off, input int bound, output int fv_cyc, output int flt_cyc);
        fv_cyc  = -1;
        flt_cyc = -1;
        eng_lat = lat;
        st_cyc.delete();
        st_f.delete();
        st_s.delete();
        st_in.delete();
        @(negedge clk);
        t0 = cyc;
        for (int i = 0; i <= bound; i++) begin
            if (i > 0) @(negedge clk);
            sample_stb = (i == 0) || (i == extra_stb);
            iAud       = ((i == 0) || (i == extra_stb)) ? aud : 16'($urandom);
            enable     = !((en_off >= 0) && (i >= en_off));
            if (frame_valid && fv_cyc < 0) fv_cyc = i;
            if (fault && flt_cyc < 0) flt_cyc = i;
        end
        sample_stb = 1'b0;
        enable     = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; sample_stb = 1'b0; iAud = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (oAud !== '0) begin n_errors++; $display("FAIL reset_oaud: got %h exp 0", oAud); end
        n_checks++; if (frame_valid !== 1'b0) begin n_errors++; $display("FAIL reset_frame_valid: got %b exp 0", frame_valid); end
        n_checks++; if (eng_start !== 1'b0) begin n_errors++; $display("FAIL reset_eng_start: got %b exp 0", eng_start); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL reset_overrun: got %b exp 0", overrun); end
        n_checks++; if (fault !== 1'b0) begin n_errors++; $display("FAIL reset_fault: got %b exp 0", fault); end
        n_checks++; if (eng_filter !== 3'd0) begin n_errors++; $display("FAIL reset_eng_filter: got %0d exp 0", eng_filter); end
        n_checks++; if (eng_section !== 1'b0) begin n_errors++; $display("FAIL reset_eng_section: got %b exp 0", eng_section); end
        n_checks++; if (eng_in !== '0) begin n_errors++; $display("FAIL reset_eng_in: got %h exp 0", eng_in); end
        reset = 1'b0;
        for (int f = 0; f < NFILT; f++) exp_band[f] = '0;
        @(negedge clk);
    endtask

    task automatic test_frames();
        int fv, fl, lat, n;
        logic signed [15:0] aud;
        logic signed [DW-1:0] exp_in;
        for (int r = 0; r < 4; r++) begin
            aud = (r == 0) ? 16'sh1000 : 16'($urandom);
            lat = (r == 0) ? 4 : int'($urandom_range(1, 6));
            drive_frame(aud, lat, -1, -1, 2 * NFILT * (lat + 1) + 6, fv, fl);
            n = st_cyc.size();
            n_checks++; if (n != 2 * NFILT) begin n_errors++; $display("FAIL frame%0d_start_count: got %0d exp %0d", r, n, 2 * NFILT); end
            for (int k = 0; k < n && k < 2 * NFILT; k++) begin
                exp_in = (k % 2 == 0) ? ref_x(aud) : eng_model(ref_x(aud), k / 2, 0);
                n_checks++;
                if (st_cyc[k] != 1 + k * (lat + 1) || st_f[k] != k / 2 || st_s[k] != k % 2 || st_in[k] !== exp_in) begin
                    n_errors++;
                    $display("FAIL frame%0d_txn%0d: got cyc %0d f %0d s %0d in %h exp cyc %0d f %0d s %0d in %h",
                             r, k, st_cyc[k], st_f[k], st_s[k], st_in[k], 1 + k * (lat + 1), k / 2, k % 2, exp_in);
                end
            end
            if (r == 0 && n > 0) begin
                n_checks++; if (st_in[0] !== 27'sh0100000) begin n_errors++; $display("FAIL frame0_aligned_in: got %h exp 0100000", st_in[0]); end
            end
            n_checks++; if (fv != 2 * NFILT * (lat + 1) + 1) begin n_errors++; $display("FAIL frame%0d_fv_cycle: got %0d exp %0d", r, fv, 2 * NFILT * (lat + 1) + 1); end
            for (int f = 0; f < NFILT; f++) exp_band[f] = ref_band(aud, f);
            for (int f = 0; f < NFILT; f++) begin
                n_checks++; if (oAud[f*OW +: OW] !== exp_band[f]) begin n_errors++; $display("FAIL frame%0d_band%0d: got %h exp %h", r, f, oAud[f*OW +: OW], exp_band[f]); end
            end
            n_checks++; if (busy !== 1'b0 || overrun !== 1'b0 || fault !== 1'b0) begin n_errors++; $display("FAIL frame%0d_flags: got busy %b ovr %b flt %b exp 000", r, busy, overrun, fault); end
        end
    endtask

    task automatic test_back_to_back();
        int fv, fl;
        logic signed [15:0] aud;
        aud = 16'($urandom);
        drive_frame(aud, 4, 72, -1, 150, fv, fl);
        n_checks++; if (st_cyc.size() != 4 * NFILT) begin n_errors++; $display("FAIL b2b_start_count: got %0d exp %0d", st_cyc.size(), 4 * NFILT); end
        if (st_cyc.size() > 2 * NFILT) begin
            n_checks++; if (st_cyc[2*NFILT] != 73 || st_f[2*NFILT] != 0 || st_s[2*NFILT] != 0) begin n_errors++; $display("FAIL b2b_second_start: got cyc %0d f %0d s %0d exp cyc 73 f 0 s 0", st_cyc[2*NFILT], st_f[2*NFILT], st_s[2*NFILT]); end
        end
        n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL b2b_overrun: got %b exp 0", overrun); end
        for (int f = 0; f < NFILT; f++) exp_band[f] = ref_band(aud, f);
        n_checks++; if (oAud[6*OW +: OW] !== exp_band[6]) begin n_errors++; $display("FAIL b2b_band6: got %h exp %h", oAud[6*OW +: OW], exp_band[6]); end
    endtask

    task automatic test_overrun();
        int fv, fl;
        logic signed [15:0] aud;
        do_reset();
        aud = 16'($urandom);
        drive_frame(aud, 4, 30, -1, 80, fv, fl);
        n_checks++; if (st_cyc.size() != 2 * NFILT) begin n_errors++; $display("FAIL ovr30_start_count: got %0d exp %0d", st_cyc.size(), 2 * NFILT); end
        n_checks++; if (fv != 71) begin n_errors++; $display("FAIL ovr30_fv_cycle: got %0d exp 71", fv); end
        n_checks++; if (overrun !== 1'b1) begin n_errors++; $display("FAIL ovr30_overrun: got %b exp 1", overrun); end
        do_reset();
        drive_frame(aud, 4, 71, -1, 80, fv, fl);
        n_checks++; if (overrun !== 1'b1) begin n_errors++; $display("FAIL ovr71_overrun: got %b exp 1", overrun); end
        n_checks++; if (st_cyc.size() != 2 * NFILT || busy !== 1'b0) begin n_errors++; $display("FAIL ovr71_dropped: got starts %0d busy %b exp %0d 0", st_cyc.size(), busy, 2 * NFILT); end
        for (int f = 0; f < NFILT; f++) exp_band[f] = ref_band(aud, f);
    endtask

    task automatic test_fault();
        int fv, fl;
        logic signed [15:0] aud;
        do_reset();
        aud = 16'($urandom);
        drive_frame(aud, 4, -1, -1, 76, fv, fl);
        for (int f = 0; f < NFILT; f++) exp_band[f] = ref_band(aud, f);
        aud = 16'($urandom);
        withhold = 1'b1; wh_f = 3; wh_s = 1;
        drive_frame(aud, 4, -1, -1, 110, fv, fl);
        withhold = 1'b0;
        for (int f = 0; f < 3; f++) exp_band[f] = ref_band(aud, f);
        n_checks++; if (fl != 36 + TIMEOUT + 1) begin n_errors++; $display("FAIL fault_cycle: got %0d exp %0d", fl, 36 + TIMEOUT + 1); end
        n_checks++; if (fv != -1) begin n_errors++; $display("FAIL fault_no_fv: got %0d exp -1", fv); end
        n_checks++; if (busy !== 1'b0 || st_cyc.size() != 8) begin n_errors++; $display("FAIL fault_idle: got busy %b starts %0d exp 0 8", busy, st_cyc.size()); end
        for (int f = 0; f < NFILT; f++) begin
            n_checks++; if (oAud[f*OW +: OW] !== exp_band[f]) begin n_errors++; $display("FAIL fault_band%0d: got %h exp %h", f, oAud[f*OW +: OW], exp_band[f]); end
        end
        // Latency of exactly TIMEOUT cycles must still be accepted.
        do_reset();
        aud = 16'($urandom);
        drive_frame(aud, TIMEOUT, -1, -1, 2 * NFILT * (TIMEOUT + 1) + 5, fv, fl);
        n_checks++; if (fl != -1 || fault !== 1'b0) begin n_errors++; $display("FAIL tmo_edge_fault: got cyc %0d fault %b exp -1 0", fl, fault); end
        n_checks++; if (fv != 2 * NFILT * (TIMEOUT + 1) + 1) begin n_errors++; $display("FAIL tmo_edge_fv: got %0d exp %0d", fv, 2 * NFILT * (TIMEOUT + 1) + 1); end
        for (int f = 0; f < NFILT; f++) exp_band[f] = ref_band(aud, f);
        n_checks++; if (oAud[3*OW +: OW] !== exp_band[3]) begin n_errors++; $display("FAIL tmo_edge_band3: got %h exp %h", oAud[3*OW +: OW], exp_band[3]); end
    endtask

    task automatic test_reset_midframe();
        int fv, fl, n;
        logic signed [15:0] aud;
        aud = 16'($urandom);
        eng_lat = 4;
        st_cyc.delete(); st_f.delete(); st_s.delete(); st_in.delete();
        @(negedge clk);
        t0 = cyc;
        inject_cyc = t0 + 42;
        sample_stb = 1'b1; iAud = aud; enable = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            sample_stb = 1'b0;
            reset = (i == 40);
            if (i == 41) begin
                n_checks++; if (busy !== 1'b0 || eng_start !== 1'b0 || oAud !== '0) begin n_errors++; $display("FAIL rst_mid_state: got busy %b start %b oaud %h exp 0 0 0", busy, eng_start, oAud); end
            end
        end
        reset = 1'b0;
        inject_cyc = -1;
        for (int f = 0; f < NFILT; f++) exp_band[f] = '0;
        n = st_cyc.size();
        n_checks++; if (n != 8 || busy !== 1'b0 || oAud !== '0) begin n_errors++; $display("FAIL rst_late_done: got starts %0d busy %b oaud %h exp 8 0 0", n, busy, oAud); end
        aud = 16'($urandom);
        drive_frame(aud, 4, -1, -1, 76, fv, fl);
        for (int f = 0; f < NFILT; f++) exp_band[f] = ref_band(aud, f);
        n_checks++; if (st_cyc.size() == 0 || st_cyc[0] != 1 || st_f[0] != 0 || st_s[0] != 0) begin n_errors++; $display("FAIL rst_restart: got starts %0d exp first at cyc 1 f 0 s 0", st_cyc.size()); end
        n_checks++; if (fv != 71 || oAud[5*OW +: OW] !== exp_band[5]) begin n_errors++; $display("FAIL rst_restart_frame: got fv %0d band5 %h exp 71 %h", fv, oAud[5*OW +: OW], exp_band[5]); end
    endtask

    task automatic test_enable();
        int fv, fl;
        logic signed [15:0] aud;
        do_reset();
        aud = 16'($urandom);
        drive_frame(aud, 4, -1, 0, 20, fv, fl);
        n_checks++; if (st_cyc.size() != 0 || busy !== 1'b0 || overrun !== 1'b0 || fv != -1) begin n_errors++; $display("FAIL en_low_ignored: got starts %0d busy %b ovr %b fv %0d exp 0 0 0 -1", st_cyc.size(), busy, overrun, fv); end
        drive_frame(aud, 4, -1, 20, 80, fv, fl);
        for (int f = 0; f < NFILT; f++) exp_band[f] = ref_band(aud, f);
        n_checks++; if (fv != 71 || st_cyc.size() != 2 * NFILT) begin n_errors++; $display("FAIL en_drop_frame: got fv %0d starts %0d exp 71 %0d", fv, st_cyc.size(), 2 * NFILT); end
        for (int f = 0; f < NFILT; f++) begin
            n_checks++; if (oAud[f*OW +: OW] !== exp_band[f]) begin n_errors++; $display("FAIL en_drop_band%0d: got %h exp %h", f, oAud[f*OW +: OW], exp_band[f]); end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; sample_stb = 1'b0; iAud = '0;
        test_reset();
        test_frames();
        test_back_to_back();
        test_overrun();
        test_fault();
        test_reset_midframe();
        test_enable();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, got cycle %0d", cyc);
        $fatal(1, "bench timeout");
    end

endmodule
